// File: rtl/barrel_rightshifter_16bit_pipe_if.sv
// Handshake/data bundle for the pipelined right barrel shifter.
//   master : operand source + result sink (drives in_valid/in/ctrl/arith/out_ready)
//   slave  : the shifter (drives in_ready/out_valid/out)
// Signals:
//   in_valid / in_ready   input-side handshake
//   in, ctrl, arith       operand, shift amount, 1 = sign fill / 0 = zero fill
//   out_valid / out_ready output-side handshake
//   out                   shifted result (0 whenever out_valid is low)
interface barrel_rightshifter_16bit_pipe_if #(
  parameter int WIDTH = 16,
  parameter int CTRLW = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [CTRLW-1:0] ctrl;
  logic             arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid, in, ctrl, arith, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, ctrl, arith, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/barrel_rightshifter_16bit_pipe.sv
// Pipelined logical/arithmetic right barrel shifter.
// One registered stage per shift-amount bit, largest shift first: stage 1
// applies the 2^(CTRLW-1) shift while capturing the operand, the last stage
// applies the shift by 1 and drives the result. Latency CTRLW clocks, one
// result per clock, single global advance enable.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every stage
//   bus    barrel_rightshifter_16bit_pipe_if slave modport (handshakes + data)
module barrel_rightshifter_16bit_pipe #(
  parameter int WIDTH = 16,
  parameter int CTRLW = 4
) (
  input logic                            clk,
  input logic                            rst_n,
  barrel_rightshifter_16bit_pipe_if.slave bus
);

  // Per-stage registers. The shift-amount copy is shifted left as it travels,
  // so the bit a stage consumes is always the MSB of what it receives.
  logic             vld_q   [1:CTRLW];
  logic [WIDTH-1:0] data_q  [1:CTRLW];
  logic [CTRLW-1:0] ctrl_q  [1:CTRLW-1];
  logic             arith_q [1:CTRLW-1];
  logic             sign_q  [1:CTRLW-1];
  logic             adv;

  // Fill with ones is done as complement / logical shift / complement, which
  // keeps every shift a plain vector shift of the operand width.
  function automatic logic [WIDTH-1:0] shr_stage(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input int               sh,
    input logic             fill
  );
    if (!en)
      return d;
    else if (fill)
      return ~((~d) >> sh);
    else
      return d >> sh;
  endfunction

  assign adv          = !vld_q[CTRLW] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_q[CTRLW];
  assign bus.out       = vld_q[CTRLW] ? data_q[CTRLW] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= CTRLW; k++) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
      end
      for (int k = 1; k < CTRLW; k++) begin
        ctrl_q[k]  <= '0;
        arith_q[k] <= 1'b0;
        sign_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      // Sign is taken from the original operand and carried with the item,
      // so later stages fill from it rather than from partially shifted data.
      vld_q[1]   <= bus.in_valid;
      data_q[1]  <= shr_stage(bus.in, bus.ctrl[CTRLW-1], 1 << (CTRLW-1),
                              bus.arith && bus.in[WIDTH-1]);
      ctrl_q[1]  <= bus.ctrl << 1;
      arith_q[1] <= bus.arith;
      sign_q[1]  <= bus.in[WIDTH-1];
      for (int k = 2; k <= CTRLW; k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= shr_stage(data_q[k-1], ctrl_q[k-1][CTRLW-1], 1 << (CTRLW-k),
                               arith_q[k-1] && sign_q[k-1]);
      end
      for (int k = 2; k < CTRLW; k++) begin
        ctrl_q[k]  <= ctrl_q[k-1] << 1;
        arith_q[k] <= arith_q[k-1];
        sign_q[k]  <= sign_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_barrel_rightshifter_16bit_pipe.sv
module tb_barrel_rightshifter_16bit_pipe;
  localparam int W = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barrel_rightshifter_16bit_pipe_if #(.WIDTH(W), .CTRLW(C)) bus ();

  barrel_rightshifter_16bit_pipe #(.WIDTH(W), .CTRLW(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int nrecv = 0;
  int rdy_mode = 0;          // 0: always ready, 1: never ready, 2: random
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference: plain arithmetic/logical right shift of the whole operand.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh, input bit a);
    logic signed [W-1:0] s;
    s = d;
    if (a) return s >>> sh;
    else   return d >> sh;
  endfunction

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard whenever a result is handed over.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] po = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_data", bus.out, po);
      end
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (!bus.out_valid) begin
        check("idle_out_zero", bus.out, 0);
      end else if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", bus.out);
        end else begin
          check("result", bus.out, exp_q.pop_front());
          nrecv++;
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      po = bus.out;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [C-1:0] c, input bit a,
                      input logic [W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    bus.in = d;
    bus.ctrl = c;
    bus.arith = a;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) fail_now("accept");
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] d;
    logic [C-1:0] c;
    bit a;
    d = W'($urandom);
    c = C'($urandom_range(0, 15));
    a = 1'($urandom_range(0, 1));
    send(d, c, a, ref_shift(d, int'(c), a));
  endtask

  // Called right after send returns (one time unit past the accept edge).
  task automatic lat_check(input string name);
    int n;
    n = 1;
    while (!bus.out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in = '0;
    bus.ctrl = '0;
    bus.arith = 1'b0;
    rdy_mode = 0;

    #12;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out", bus.out, 0);
    check("reset_in_ready", bus.in_ready, 1);
    #11;
    rst_n = 1'b1;

    // Directed values and latency
    send(16'h8000, 4'd15, 1'b0, 16'h0001);
    lat_check("latency_first");
    drain();
    send(16'h8000, 4'd4, 1'b1, 16'hF800);
    send(16'h7FFF, 4'd15, 1'b1, 16'h0000);
    send(16'hA5A5, 4'd0, 1'b0, 16'hA5A5);
    send(16'hA5A5, 4'd0, 1'b1, 16'hA5A5);
    send(16'd10, 4'd1, 1'b0, 16'd5);
    send(16'h8001, 4'd15, 1'b1, 16'hFFFF);
    send(16'h4321, 4'd15, 1'b0, 16'h0000);
    drain();

    // Back-to-back stream with a 5-cycle output stall after the first result
    base = nrecv;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [W-1:0] d;
          logic [C-1:0] c;
          d = 16'h9234 + W'(i * 16'h1111);
          c = C'(i + 2);
          send(d, c, i[0], ref_shift(d, int'(c), i[0]));
        end
      end
      begin
        int n;
        n = 0;
        while (nrecv == base && n < 100) begin
          @(negedge clk);
          #3;
          n++;
        end
        if (nrecv == base) fail_now("stall_first_result");
        rdy_mode = 1;
        repeat (5) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", bus.in_ready, 0);
        end
        rdy_mode = 0;
      end
    join
    drain();
    check("stall_count", nrecv - base, 6);

    // Asynchronous reset with items in flight
    send(16'h8001, 4'd1, 1'b0, 16'h4000);
    send(16'hC000, 4'd2, 1'b1, 16'hF000);
    send(16'h00F0, 4'd4, 1'b0, 16'h000F);
    @(posedge clk);
    #3;
    check("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", bus.out_valid, 0);
    check("async_reset_out", bus.out, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", bus.out_valid, 0);
    end
    send(16'hFFF0, 4'd3, 1'b1, 16'hFFFE);
    lat_check("latency_after_reset");
    drain();

    // Random sweep with random backpressure and input gaps
    rdy_mode = 2;
    base = nrecv;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_rand();
    end
    rdy_mode = 0;
    drain();
    check("random_count", nrecv - base, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
